// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode / write-back stage.
// Decodes srcA/srcB/dstE/dstM from fetch fields, reads a 15 x DATA_W register
// file asynchronously, commits valE/valM at the clock edge, and tracks a sticky
// halted flag and a retired-instruction counter.
// Optional feature: define WB_BYPASS_EN to forward the pending write-back onto
// valA/valB in the same cycle.
module decode_writeback #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              instr_valid,
  input  logic              wb_en,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] RegNone = 4'hF;
  localparam logic [3:0] RegRsp  = 4'h4;

  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] IRrmov  = 4'h2;
  localparam logic [3:0] IIrmov  = 4'h3;
  localparam logic [3:0] IRmmov  = 4'h4;
  localparam logic [3:0] IMrmov  = 4'h5;
  localparam logic [3:0] IOp     = 4'h6;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPush   = 4'hA;
  localparam logic [3:0] IPop    = 4'hB;

  logic [DATA_W-1:0] regs_q [15];
  logic [DATA_W-1:0] regs_d [15];
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              commit;
  logic              halt_now;
  logic              do_write;
  logic [DATA_W-1:0] stored_a, stored_b;

  // Combinational decode of register specifiers; unlisted icodes select none.
  always_comb begin
    srcA = RegNone;
    srcB = RegNone;
    dstE = RegNone;
    dstM = RegNone;
    case (icode)
      IRrmov: begin
        srcA = rA;
        if (cnd) dstE = rB;
      end
      IIrmov: dstE = rB;
      IRmmov: begin
        srcA = rA;
        srcB = rB;
      end
      IMrmov: begin
        srcB = rB;
        dstM = rA;
      end
      IOp: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      ICall: begin
        srcB = RegRsp;
        dstE = RegRsp;
      end
      IRet: begin
        srcA = RegRsp;
        srcB = RegRsp;
        dstE = RegRsp;
      end
      IPush: begin
        srcA = rA;
        srcB = RegRsp;
        dstE = RegRsp;
      end
      IPop: begin
        srcA = RegRsp;
        srcB = RegRsp;
        dstE = RegRsp;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // Commit qualifiers: a halting/invalid instruction retires but never writes.
  always_comb begin
    commit   = wb_en & ~halted_q;
    halt_now = commit & ((icode == IHalt) | ~instr_valid);
    do_write = commit & ~halt_now;
  end

  // Register-file next state; the M write is applied last so it wins on dstE == dstM.
  always_comb begin
    regs_d = regs_q;
    if (do_write) begin
      if (dstE != RegNone) regs_d[dstE] = valE;
      if (dstM != RegNone) regs_d[dstM] = valM;
    end
  end

  // Status next state: halted is sticky, retired counts every commit and wraps.
  always_comb begin
    halted_d  = halted_q | halt_now;
    retired_d = commit ? retired_q + CNT_W'(1) : retired_q;
  end

  // State registers with asynchronous reset; %rsp gets its own reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      regs_q[RegRsp] <= RSP_RESET;
      halted_q       <= 1'b0;
      retired_q      <= '0;
    end else begin
      regs_q    <= regs_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // Asynchronous operand reads; a "none" specifier reads as zero.
  always_comb begin
    stored_a = (srcA == RegNone) ? '0 : regs_q[srcA];
    stored_b = (srcB == RegNone) ? '0 : regs_q[srcB];
  end

`ifdef WB_BYPASS_EN
  // Forward the value being committed this cycle; valM takes priority over valE.
  always_comb begin
    valA = stored_a;
    valB = stored_b;
    if (commit && srcA != RegNone) begin
      if (srcA == dstM)      valA = valM;
      else if (srcA == dstE) valA = valE;
    end
    if (commit && srcB != RegNone) begin
      if (srcB == dstM)      valB = valM;
      else if (srcB == dstE) valB = valE;
    end
  end
`else
  // Reads return stored contents only; new values appear after the edge.
  always_comb begin
    valA = stored_a;
    valB = stored_b;
  end
`endif

  // Status outputs.
  always_comb begin
    halted  = halted_q;
    retired = retired_q;
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios followed by
// randomized traffic compared against a behavioural register-file model.
module tb_decode_writeback;

  localparam int unsigned DW  = 64;
  localparam int unsigned CW  = 8;
  localparam logic [63:0] RSP = 64'h0000_0000_0000_F000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    icode, rA, rB;
  logic          cnd, instr_valid, wb_en;
  logic [DW-1:0] valE, valM;
  logic [3:0]    srcA, srcB, dstE, dstM;
  logic [DW-1:0] valA, valB;
  logic          halted;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  decode_writeback #(
    .DATA_W   (DW),
    .RSP_RESET(RSP),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .icode      (icode),
    .rA         (rA),
    .rB         (rB),
    .cnd        (cnd),
    .valE       (valE),
    .valM       (valM),
    .instr_valid(instr_valid),
    .wb_en      (wb_en),
    .srcA       (srcA),
    .srcB       (srcB),
    .dstE       (dstE),
    .dstM       (dstM),
    .valA       (valA),
    .valB       (valB),
    .halted     (halted),
    .retired    (retired)
  );

  int errors = 0;
  int checks = 0;

  // Reference state.
  logic [63:0] m_reg [15];
  bit          m_halted;
  int unsigned m_retired;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decode table straight from the instruction set definition.
  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return ra;
      4'h9, 4'hB:             return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h4, 4'h5, 4'h6:       return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb,
                                         input logic c);
    case (ic)
      4'h2:                   return c ? rb : 4'hF;
      4'h3, 4'h6:             return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] a, input logic [3:0] de,
                                         input logic [3:0] dm);
    logic [63:0] v;
    v = (a == 4'hF) ? 64'd0 : m_reg[a];
`ifdef WB_BYPASS_EN
    if (wb_en && !m_halted && a != 4'hF) begin
      if (a == dm)      v = valM;
      else if (a == de) v = valE;
    end
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
    m_reg[4]  = RSP;
    m_halted  = 1'b0;
    m_retired = 0;
  endtask

  task automatic model_edge();
    logic [3:0] de, dm;
    de = m_dst_e(icode, rB, cnd);
    dm = m_dst_m(icode, rA);
    if (wb_en && !m_halted) begin
      m_retired++;
      if (icode == 4'h0 || !instr_valid) m_halted = 1'b1;
      else begin
        if (de != 4'hF) m_reg[de] = valE;
        if (dm != 4'hF) m_reg[dm] = valM;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] sa, sb, de, dm;
    sa = m_src_a(icode, rA);
    sb = m_src_b(icode, rB);
    de = m_dst_e(icode, rB, cnd);
    dm = m_dst_m(icode, rA);
    check("srcA", {60'd0, srcA}, {60'd0, sa});
    check("srcB", {60'd0, srcB}, {60'd0, sb});
    check("dstE", {60'd0, dstE}, {60'd0, de});
    check("dstM", {60'd0, dstM}, {60'd0, dm});
    check("valA", valA, m_read(sa, de, dm));
    check("valB", valB, m_read(sb, de, dm));
    check("halted", {63'd0, halted}, {63'd0, m_halted});
    check("retired", {56'd0, retired}, {56'd0, m_retired[7:0]});
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm,
                       input logic iv, input logic we);
    icode = ic; rA = ra; rB = rb; cnd = c;
    valE = ve; valM = vm; instr_valid = iv; wb_en = we;
  endtask

  // Check combinational outputs mid-cycle, then let the edge commit.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Read one register through both ports without committing.
  task automatic read_reg(input logic [3:0] r);
    drive(4'h6, r, r, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    cycle();
  endtask

  // Assert reset away from any clock edge and check the immediate clear.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    #1;
    check_all();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset contents of every register.
    for (int r = 0; r < 15; r++) read_reg(4'(r));

    // irmovq $0x1234, %rdx then rrmovq %rdx read-back.
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'd0, 1'b1, 1'b1);
    cycle();
    drive(4'h2, 4'h2, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0);
    cycle();

    // cmovXX %rdx, %rbx: not taken, then taken.
    drive(4'h2, 4'h2, 4'h3, 1'b0, 64'h1234, 64'd0, 1'b1, 1'b1);
    cycle();
    read_reg(4'h3);
    drive(4'h2, 4'h2, 4'h3, 1'b1, 64'h1234, 64'd0, 1'b1, 1'b1);
    cycle();
    read_reg(4'h3);

    // popq %rsp: M write wins over E write.
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h200, 1'b1, 1'b1);
    cycle();
    read_reg(4'h4);

    // OPq %rcx, %rcx: same-cycle view depends on forwarding.
    drive(4'h6, 4'h1, 4'h1, 1'b0, 64'h55, 64'd0, 1'b1, 1'b1);
    cycle();
    read_reg(4'h1);

    // halt, then a blocked irmovq to %rbp.
    drive(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
    cycle();
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'hABCD, 64'd0, 1'b1, 1'b1);
    cycle();
    read_reg(4'h5);
    mid_reset();
    read_reg(4'h2);

    // Counter wrap with a narrow counter.
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
    repeat (300) cycle();

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] ic;
      if ($urandom_range(0, 299) == 0) mid_reset();
      ic = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 63) == 0) ic = 4'h0;
      drive(ic, 4'($urandom), 4'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 63) != 0, 1'($urandom));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
